gf180mcu_fd_sc_mcu9t5v0__dlyfilt: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv | 108 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv
// gf180mcu_fd_sc_mcu9t5v0__dlyfilt: deglitch/qualify filter behind a delay cell.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   I    asynchronous level from the upstream delay cell
//   Z    filtered, synchronised level
//   ZR   one-cycle strobe when Z goes 0->1
//   ZF   one-cycle strobe when Z goes 1->0
//   BUSY high while a candidate transition is being qualified
//   BYP  (only with GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN) Z follows
//        the synchronised input every edge
// Optional macro: GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
module gf180mcu_fd_sc_mcu9t5v0__dlyfilt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 8
) (
  input  logic CLK,
  input  logic RST,
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
  input  logic BYP,
`endif
  input  logic I,
  output logic Z,
  output logic ZR,
  output logic ZF,
  output logic BUSY
);

  localparam int CNT_W = $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_CNT - 1);

  typedef enum logic {
    IDLE,
    QUAL
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  logic z_n;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      Z     <= 1'b0;
      ZR    <= 1'b0;
      ZF    <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      sync[0] <= I;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync[k] <= sync[k-1];
      state <= state_n;
      cnt   <= cnt_n;
      Z     <= z_n;
      // strobes derive from the actual Z change, so every path
      // that moves Z (filter or bypass) produces exactly one pulse
      ZR    <= z_n & ~Z;
      ZF    <= ~z_n & Z;
      BUSY  <= (state_n == QUAL);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    z_n     = Z;
    unique case (state)
      IDLE: begin
        if (s != Z) begin
          // a one-sample window qualifies on the very first edge
          if (FILT_CNT == 1) begin
            z_n = s;
          end else begin
            state_n = QUAL;
            cnt_n   = ONE;
          end
        end
      end
      QUAL: begin
        if (s == Z) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          z_n     = s;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    endcase
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
    if (BYP) begin
      state_n = IDLE;
      cnt_n   = '0;
      z_n     = s;
    end
`endif
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv
// Testbench for gf180mcu_fd_sc_mcu9t5v0__dlyfilt: default build plus a
// FILT_CNT=1/SYNC_STAGES=1 instance, directed vectors, hand-computed results.
module tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt;

  logic clk = 1'b0;
  logic rst;
  logic i0, i1;
  logic z0, zr0, zf0, busy0;
  logic z1, zr1, zf1, busy1;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
  logic byp0, byp1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__dlyfilt dut (
    .CLK (clk),
    .RST (rst),
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
    .BYP (byp0),
`endif
    .I   (i0),
    .Z   (z0),
    .ZR  (zr0),
    .ZF  (zf0),
    .BUSY(busy0)
  );

  gf180mcu_fd_sc_mcu9t5v0__dlyfilt #(
    .SYNC_STAGES(1),
    .FILT_CNT   (1)
  ) dut1 (
    .CLK (clk),
    .RST (rst),
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
    .BYP (byp1),
`endif
    .I   (i1),
    .Z   (z1),
    .ZR  (zr1),
    .ZF  (zf1),
    .BUSY(busy1)
  );

  // advance one edge; inputs change and outputs are read 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {Z,ZR,ZF,BUSY} of the default instance
  function automatic logic [3:0] obs0();
    return {z0, zr0, zf0, busy0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i0  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (obs0() !== 4'b0000) begin
        errors++;
        $display("FAIL reset edge %0d: got %b want 0000", k, obs0());
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      logic [3:0] exp;
      step();
      exp = {k >= 10, k == 10, 1'b0, k >= 3 && k <= 9};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL post_reset edge %0d: got %b want %b",
                 k, obs0(), exp);
      end
    end
  endtask

  // drive I to lvl (opposite of current Z) and hold for 20 edges
  task automatic test_clean(input logic lvl);
    i0 = lvl;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp;
      step();
      exp = {(k >= 10) ? lvl : ~lvl,
             lvl & (k == 10),
             ~lvl & (k == 10),
             k >= 3 && k <= 9};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL clean_%0d edge %0d: got %b want %b",
                 lvl, k, obs0(), exp);
      end
    end
  endtask

  task automatic test_glitch();
    i0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] exp;
      step();
      exp = {3'b000, k >= 3 && k <= 7};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL glitch edge %0d: got %b want %b", k, obs0(), exp);
      end
      if (k == 5) i0 = 1'b0;
    end
  endtask

  task automatic test_toggle();
    for (int k = 1; k <= 30; k++) begin
      i0 = ~i0;
      step();
      checks++;
      if ({z0, zr0, zf0} !== 3'b000) begin
        errors++;
        $display("FAIL toggle edge %0d: got %b want 000",
                 k, {z0, zr0, zf0});
      end
    end
    i0 = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_qual();
    i0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      logic [3:0] exp;
      step();
      exp = {3'b000, k >= 3};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL midq edge %0d: got %b want %b", k, obs0(), exp);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (obs0() !== 4'b0000) begin
      errors++;
      $display("FAIL midq reset: got %b want 0000", obs0());
    end
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      logic [3:0] exp;
      step();
      exp = {k >= 10, k == 10, 1'b0, k >= 3 && k <= 9};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL midq release edge %0d: got %b want %b",
                 k, obs0(), exp);
      end
    end
  endtask

  task automatic test_fast_filter();
    i1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      logic [3:0] exp;
      step();
      exp = {k >= 2, k == 2, 2'b00};
      checks++;
      if ({z1, zr1, zf1, busy1} !== exp) begin
        errors++;
        $display("FAIL fast_rise edge %0d: got %b want %b",
                 k, {z1, zr1, zf1, busy1}, exp);
      end
    end
    i1 = 1'b0;
    repeat (4) step();
    checks++;
    if ({z1, zr1, zf1, busy1} !== 4'b0000) begin
      errors++;
      $display("FAIL fast_fall: got %b want 0000", {z1, zr1, zf1, busy1});
    end
    i1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] exp;
      step();
      i1 = 1'b0;
      exp = {k == 2, k == 2, k == 3, 1'b0};
      checks++;
      if ({z1, zr1, zf1, busy1} !== exp) begin
        errors++;
        $display("FAIL fast_pulse edge %0d: got %b want %b",
                 k, {z1, zr1, zf1, busy1}, exp);
      end
    end
  endtask

`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
  task automatic test_bypass();
    byp0 = 1'b1;
    i0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] exp;
      step();
      i0 = 1'b0;
      exp = {k == 3, k == 3, k == 4, 1'b0};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL bypass_on edge %0d: got %b want %b",
                 k, obs0(), exp);
      end
    end
    byp0 = 1'b0;
    i0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [3:0] exp;
      step();
      i0 = 1'b0;
      exp = {3'b000, k == 3};
      checks++;
      if (obs0() !== exp) begin
        errors++;
        $display("FAIL bypass_off edge %0d: got %b want %b",
                 k, obs0(), exp);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    i0  = 1'b0;
    i1  = 1'b0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
    byp0 = 1'b0;
    byp1 = 1'b0;
`endif
    test_reset();
    test_clean(1'b0);
    test_clean(1'b1);
    test_clean(1'b0);
    test_glitch();
    test_toggle();
    test_reset_mid_qual();
    test_clean(1'b0);
    test_fast_filter();
`ifdef GF180MCU_FD_SC_MCU9T5V0_DLYFILT_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
